// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: ID-stage operand/HI-LO info and EX/MEM/WB
// register-file write info flow into the controller; stall/bubble controls,
// forwarding selects and MDU status flow back to the pipeline.
//   master : pipeline side (drives stage info, receives controls)
//   slave  : hazard controller side
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       id_hilo_use;
    logic       id_is_mult;
    logic       id_is_div;
    logic       ex_rf_wena;
    logic [4:0] ex_rf_waddr;
    logic       ex_mux_rf_DMEM;
    logic       mem_rf_wena;
    logic [4:0] mem_rf_waddr;
    logic       wb_rf_wena;
    logic [4:0] wb_rf_waddr;
    logic       stall_pc;
    logic       stall_fd;
    logic       bubble_de;
    logic [1:0] fwd_rs;
    logic [1:0] fwd_rt;
    logic       mdu_busy;
    logic       mdu_done;

    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used, id_hilo_use,
               id_is_mult, id_is_div, ex_rf_wena, ex_rf_waddr, ex_mux_rf_DMEM,
               mem_rf_wena, mem_rf_waddr, wb_rf_wena, wb_rf_waddr,
        input  stall_pc, stall_fd, bubble_de, fwd_rs, fwd_rt, mdu_busy, mdu_done
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used, id_hilo_use,
               id_is_mult, id_is_div, ex_rf_wena, ex_rf_waddr, ex_mux_rf_DMEM,
               mem_rf_wena, mem_rf_waddr, wb_rf_wena, wb_rf_waddr,
        output stall_pc, stall_fd, bubble_de, fwd_rs, fwd_rt, mdu_busy, mdu_done
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : pipe_hazard_ctrl_if.slave -- ID/EX/MEM/WB info in; stall_pc,
//          stall_fd, bubble_de, fwd_rs, fwd_rt (combinational) and
//          mdu_busy, mdu_done (registered) out.
// Forwarding priority is EX > MEM > WB. A load in EX that matches a used
// source register raises a load-use stall instead of forwarding. The MULT/DIV
// scheduler holds any HI/LO user in ID until the unit is idle again.
module pipe_hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MBUSY, DBUSY} state_t;

    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [5:0] cnt_reg, cnt_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;

    // Operand 0 is rs, operand 1 is rt.
    logic [1:0][4:0] src;
    logic [1:0]      used;
    logic [1:0][1:0] fwd;
    logic [1:0]      ex_hit, mem_hit, wb_hit, load_hit;

    logic lu, md_stall, stall, issue;

    assign src[0]  = bus.id_rs;
    assign src[1]  = bus.id_rt;
    assign used[0] = bus.id_rs_used;
    assign used[1] = bus.id_rt_used;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            // A hit needs a used, nonzero source; r0 never forwards.
            assign ex_hit[gi]  = used[gi] && (src[gi] != 5'd0) &&
                                 bus.ex_rf_wena && (bus.ex_rf_waddr == src[gi]);
            assign mem_hit[gi] = used[gi] && (src[gi] != 5'd0) &&
                                 bus.mem_rf_wena && (bus.mem_rf_waddr == src[gi]);
            assign wb_hit[gi]  = used[gi] && (src[gi] != 5'd0) &&
                                 bus.wb_rf_wena && (bus.wb_rf_waddr == src[gi]);
            assign load_hit[gi] = ex_hit[gi] && bus.ex_mux_rf_DMEM;
            // An EX load hit blocks lower-priority stages; the stall makes
            // the select irrelevant that cycle, so it reads 0.
            assign fwd[gi] = ex_hit[gi]  ? (bus.ex_mux_rf_DMEM ? 2'd0 : 2'd1) :
                             mem_hit[gi] ? 2'd2 :
                             wb_hit[gi]  ? 2'd3 : 2'd0;
        end
    endgenerate

    assign lu       = |load_hit;
    assign md_stall = bus.id_hilo_use && (state_reg != IDLE);
    assign stall    = lu || md_stall;
    assign issue    = (state_reg == IDLE) && !stall && (bus.id_is_mult || bus.id_is_div);

    assign bus.stall_pc  = stall;
    assign bus.stall_fd  = stall;
    assign bus.bubble_de = stall;
    assign bus.fwd_rs    = fwd[0];
    assign bus.fwd_rt    = fwd[1];
    assign bus.mdu_busy  = busy_reg;
    assign bus.mdu_done  = done_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 6'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (issue) begin
                    // DIV takes precedence when both flags are set.
                    if (bus.id_is_div) begin
                        state_next = DBUSY;
                        cnt_next   = DIV_LOAD;
                    end else begin
                        state_next = MBUSY;
                        cnt_next   = MULT_LOAD;
                    end
                end
            end
            MBUSY, DBUSY: begin
                if (cnt_reg == 6'd0) begin
                    // Leaving busy: the next cycle is the done cycle, which
                    // also releases any stalled HI/LO user.
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 6'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all checked against a cycle-count reference model.
module tb_pipe_hazard_ctrl;
    localparam int MC = 4;
    localparam int DC = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: remaining busy cycles and pending done pulse.
    int busy_left = 0;
    bit done_m    = 1'b0;

    // Last observed outputs (captured at the check point of each cycle).
    logic       obs_stall, obs_done, obs_busy;
    logic [1:0] obs_fwd_rs, obs_fwd_rt;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected select from the forwarding rules; dc=1 when don't-care.
    task automatic model_fwd(input logic [4:0] r, input logic u,
                             output logic [1:0] sel, output bit dc);
        sel = 2'd0;
        dc  = 1'b0;
        if (u && r != 5'd0) begin
            if (bus.ex_rf_wena && bus.ex_rf_waddr == r) begin
                if (bus.ex_mux_rf_DMEM) dc = 1'b1;
                else sel = 2'd1;
            end else if (bus.mem_rf_wena && bus.mem_rf_waddr == r) sel = 2'd2;
            else if (bus.wb_rf_wena && bus.wb_rf_waddr == r) sel = 2'd3;
        end
    endtask

    task automatic nop();
        bus.id_rs = 5'd0;  bus.id_rt = 5'd0;
        bus.id_rs_used = 1'b0; bus.id_rt_used = 1'b0;
        bus.id_hilo_use = 1'b0; bus.id_is_mult = 1'b0; bus.id_is_div = 1'b0;
        bus.ex_rf_wena = 1'b0; bus.ex_rf_waddr = 5'd0; bus.ex_mux_rf_DMEM = 1'b0;
        bus.mem_rf_wena = 1'b0; bus.mem_rf_waddr = 5'd0;
        bus.wb_rf_wena = 1'b0; bus.wb_rf_waddr = 5'd0;
    endtask

    // One clock: check at negedge, advance model at posedge, return at +1.
    task automatic cycle();
        logic [1:0] e_rs, e_rt;
        bit dc_rs, dc_rt, lu, st, iss;
        @(negedge clk);
        model_fwd(bus.id_rs, bus.id_rs_used, e_rs, dc_rs);
        model_fwd(bus.id_rt, bus.id_rt_used, e_rt, dc_rt);
        lu = bus.ex_rf_wena && bus.ex_mux_rf_DMEM && bus.ex_rf_waddr != 5'd0 &&
             ((bus.id_rs_used && bus.id_rs == bus.ex_rf_waddr) ||
              (bus.id_rt_used && bus.id_rt == bus.ex_rf_waddr));
        st  = lu || (bus.id_hilo_use && busy_left > 0);
        iss = (busy_left == 0) && !st && (bus.id_is_mult || bus.id_is_div);
        chk("stall_pc", 8'(bus.stall_pc), 8'(st));
        chk("stall_fd", 8'(bus.stall_fd), 8'(st));
        chk("bubble_de", 8'(bus.bubble_de), 8'(st));
        if (!dc_rs) chk("fwd_rs", 8'(bus.fwd_rs), 8'(e_rs));
        if (!dc_rt) chk("fwd_rt", 8'(bus.fwd_rt), 8'(e_rt));
        chk("mdu_busy", 8'(bus.mdu_busy), 8'(busy_left > 0));
        chk("mdu_done", 8'(bus.mdu_done), 8'(done_m));
        obs_stall  = bus.stall_pc;
        obs_done   = bus.mdu_done;
        obs_busy   = bus.mdu_busy;
        obs_fwd_rs = bus.fwd_rs;
        obs_fwd_rt = bus.fwd_rt;
        @(posedge clk);
        if (busy_left > 0) begin
            busy_left--;
            done_m = (busy_left == 0);
        end else begin
            done_m = 1'b0;
            if (iss) busy_left = bus.id_is_div ? DC : MC;
        end
        #1;
    endtask

    initial begin
        int n;
        nop();
        // Reset state while rst is held low.
        #3;
        chk("rst_busy", 8'(bus.mdu_busy), 8'd0);
        chk("rst_done", 8'(bus.mdu_done), 8'd0);
        chk("rst_stall", 8'(bus.stall_pc), 8'd0);
        #9 rst = 1'b1;
        @(posedge clk); #1;

        // Forwarding priority EX > MEM > WB.
        bus.ex_rf_wena = 1'b1;  bus.ex_rf_waddr = 5'd8;
        bus.mem_rf_wena = 1'b1; bus.mem_rf_waddr = 5'd8;
        bus.wb_rf_wena = 1'b1;  bus.wb_rf_waddr = 5'd8;
        bus.id_rs = 5'd8; bus.id_rs_used = 1'b1;
        cycle(); chk("prio_ex", 8'(obs_fwd_rs), 8'd1);
        bus.ex_rf_wena = 1'b0;
        cycle(); chk("prio_mem", 8'(obs_fwd_rs), 8'd2);
        bus.mem_rf_wena = 1'b0;
        cycle(); chk("prio_wb", 8'(obs_fwd_rs), 8'd3);

        // Register zero never forwards or stalls.
        nop();
        bus.ex_rf_wena = 1'b1; bus.mem_rf_wena = 1'b1; bus.wb_rf_wena = 1'b1;
        bus.ex_mux_rf_DMEM = 1'b1;
        bus.id_rs_used = 1'b1; bus.id_rt_used = 1'b1;
        cycle();
        chk("zero_rs", 8'(obs_fwd_rs), 8'd0);
        chk("zero_rt", 8'(obs_fwd_rt), 8'd0);
        chk("zero_stall", 8'(obs_stall), 8'd0);

        // Load-use: one stall cycle, then MEM forwarding.
        nop();
        bus.ex_rf_wena = 1'b1; bus.ex_rf_waddr = 5'd5; bus.ex_mux_rf_DMEM = 1'b1;
        bus.id_rt = 5'd5; bus.id_rt_used = 1'b1;
        cycle(); chk("lu_stall", 8'(obs_stall), 8'd1);
        bus.ex_rf_wena = 1'b0; bus.ex_mux_rf_DMEM = 1'b0;
        bus.mem_rf_wena = 1'b1; bus.mem_rf_waddr = 5'd5;
        cycle();
        chk("lu_release", 8'(obs_stall), 8'd0);
        chk("lu_fwd_rt", 8'(obs_fwd_rt), 8'd2);

        // DIV then MFLO: 32 stalled cycles, released on the done cycle.
        nop();
        bus.id_is_div = 1'b1; bus.id_hilo_use = 1'b1;
        cycle();
        bus.id_is_div = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (!obs_stall) break;
            n++;
        end
        chk("div_stall_cycles", 8'(n), 8'(DC));
        chk("div_done_at_release", 8'(obs_done), 8'd1);

        // MULT blocked by load-use, then issued once the hazard clears.
        nop();
        bus.ex_rf_wena = 1'b1; bus.ex_rf_waddr = 5'd5; bus.ex_mux_rf_DMEM = 1'b1;
        bus.id_rs = 5'd5; bus.id_rs_used = 1'b1;
        bus.id_is_mult = 1'b1; bus.id_hilo_use = 1'b1;
        cycle(); chk("mult_blocked", 8'(obs_stall), 8'd1);
        bus.ex_rf_wena = 1'b0; bus.ex_mux_rf_DMEM = 1'b0;
        bus.mem_rf_wena = 1'b1; bus.mem_rf_waddr = 5'd5;
        cycle(); chk("mult_not_yet_busy", 8'(obs_busy), 8'd0);
        nop();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (!obs_busy) break;
            n++;
        end
        chk("mult_busy_cycles", 8'(n), 8'(MC));
        chk("mult_done", 8'(obs_done), 8'd1);

        // Reset in the middle of a divide.
        nop();
        bus.id_is_div = 1'b1; bus.id_hilo_use = 1'b1;
        cycle();
        bus.id_is_div = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        #2 rst = 1'b0;
        #1;
        busy_left = 0; done_m = 1'b0;
        chk("rst_mid_busy", 8'(bus.mdu_busy), 8'd0);
        chk("rst_mid_done", 8'(bus.mdu_done), 8'd0);
        @(posedge clk); #3 rst = 1'b1;
        cycle();
        chk("rst_mid_stall", 8'(obs_stall), 8'd0);
        chk("rst_mid_no_done", 8'(obs_done), 8'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.id_rs = 5'($urandom_range(0, 3));
            bus.id_rt = 5'($urandom_range(0, 3));
            bus.id_rs_used = 1'($urandom);
            bus.id_rt_used = 1'($urandom);
            bus.id_is_mult = ($urandom_range(0, 15) == 0);
            bus.id_is_div  = ($urandom_range(0, 31) == 0);
            bus.id_hilo_use = bus.id_is_mult || bus.id_is_div || ($urandom_range(0, 7) == 0);
            bus.ex_rf_wena = 1'($urandom);
            bus.ex_rf_waddr = 5'($urandom_range(0, 3));
            bus.ex_mux_rf_DMEM = 1'($urandom);
            bus.mem_rf_wena = 1'($urandom);
            bus.mem_rf_waddr = 5'($urandom_range(0, 3));
            bus.wb_rf_wena = 1'($urandom);
            bus.wb_rf_waddr = 5'($urandom_range(0, 3));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage MIPS pipeline.
- Generates per-rs/rt forwarding selects from EX, MEM and WB register-file write info.
- Detects load-use hazards and issues stall and bubble controls to the PC, IF/ID and ID/EX registers.
- Owns the multi-cycle MULT/DIV scheduler. Any instruction that touches HI/LO waits until the unit is free.

Parameters:
MULT_CYCLES, 4, busy cycles for MULT/MULTU (1..63)
DIV_CYCLES, 32, busy cycles for DIV/DIVU (1..63)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
id_rs  input  5  rs field of the ID-stage instruction
id_rt  input  5  rt field of the ID-stage instruction
id_rs_used  input  1  ID instruction reads rs
id_rt_used  input  1  ID instruction reads rt
id_hilo_use  input  1  ID instruction reads or writes HI/LO (includes mult/div/mfhi/mflo/mthi/mtlo)
id_is_mult  input  1  ID instruction is MULT/MULTU
id_is_div  input  1  ID instruction is DIV/DIVU
ex_rf_wena  input  1  EX-stage instruction writes the register file
ex_rf_waddr  input  5  EX-stage destination register
ex_mux_rf_DMEM  input  1  EX-stage instruction is a load (result comes from DMEM)
mem_rf_wena  input  1  MEM-stage instruction writes the register file
mem_rf_waddr  input  5  MEM-stage destination register
wb_rf_wena  input  1  WB-stage instruction writes the register file
wb_rf_waddr  input  5  WB-stage destination register
stall_pc  output  1  hold PC
stall_fd  output  1  hold IF/ID register
bubble_de  output  1  load NOP into ID/EX (rf_wena, hi_ena, lo_ena forced 0)
fwd_rs  output  2  rs operand source: 0 regfile, 1 EX result, 2 MEM result, 3 WB result
fwd_rt  output  2  rt operand source, same encoding as fwd_rs
mdu_busy  output  1  multiply/divide unit occupied (registered)
mdu_done  output  1  one-cycle pulse: HI/LO result valid this cycle (registered)

Behaviour:
Forwarding (combinational; priority EX > MEM > WB):
- Match on a stage requires: that stage's wena = 1, its waddr equals the source register, and the source register is nonzero.
- Register 0 always yields select 0.
- An EX match with ex_mux_rf_DMEM = 1 never forwards. It raises the load-use hazard instead, and the select is don't-care.
- A MEM match forwards 2 whether or not the instruction is a load; the datapath muxes DMEM data for that case.
- A used = 0 operand always yields select 0.

Load-use hazard:
- lu = ex_rf_wena & ex_mux_rf_DMEM & ex_rf_waddr != 0 & ((id_rs_used & id_rs == ex_rf_waddr) | (id_rt_used & id_rt == ex_rf_waddr)).

MDU state machine (states IDLE, MBUSY, DBUSY; 6-bit down-counter cnt):
- md_stall = id_hilo_use & (state != IDLE).
- stall = lu | md_stall. Then stall_pc = stall_fd = bubble_de = stall.
- issue = (state == IDLE) & ~stall & (id_is_mult | id_is_div).
- IDLE -> MBUSY on issue with id_is_mult, loading cnt = MULT_CYCLES - 1.
- IDLE -> DBUSY on issue with id_is_div, loading cnt = DIV_CYCLES - 1.
- If id_is_mult and id_is_div are both set, div wins.
- MBUSY/DBUSY: cnt decrements each cycle. When cnt == 0, next state is IDLE.
- mdu_busy = 1 exactly while state != IDLE. It is high for MULT_CYCLES or DIV_CYCLES cycles after the issue edge.
- mdu_done = 1 for exactly one cycle: the first IDLE cycle after a busy period.
- A HI/LO user stalled during busy is released in that same mdu_done cycle.
- A new mult/div may issue in the mdu_done cycle. mdu_done still pulses, and mdu_busy rises at the next edge.
- A stalled mult/div (lu = 1) does not issue. It issues in the cycle the stall clears.

Reset (rst = 0, asynchronous):
- State IDLE, cnt = 0, mdu_busy = 0, mdu_done = 0.
- Combinational outputs follow their equations with state IDLE.
- Reset in the middle of a busy period abandons the operation with no mdu_done pulse.

Test Plan:
- Forwarding priority: ex_rf_wena = 1, ex waddr 8, not load; mem and wb also write r8; id_rs = 8 used -> fwd_rs = 1. Clear EX write -> 2. Clear MEM write -> 3.
- Zero register: all stages write r0, id_rs = id_rt = 0, both used -> fwd_rs = fwd_rt = 0 and stall = 0.
- Load-use: EX load to r5 with id_rt = 5 used -> stall_pc = stall_fd = bubble_de = 1 for one cycle. Next cycle the load is in MEM -> stall = 0 and fwd_rt = 2.
- DIV then MFLO: DIV issued at edge t, MFLO in ID from t+1 -> mdu_busy high for 32 cycles; stall high for 32 cycles; mdu_done and stall release in the same cycle.
- MULT issue blocked by load-use, then issued: mdu_busy rises one cycle later than it would without the hazard and stays high for 4 cycles.
- Reset mid-divide: assert rst = 0 at busy cycle 10 -> mdu_busy drops immediately, no mdu_done pulse, stall = 0 after release.
